// File: rtl/neuron_accumulator.sv
// Multiply-accumulate back end of a fully-connected layer pass: consumes operand
// pairs, accumulates n_in terms per neuron, writes activated/saturated results.
module neuron_accumulator #(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 24,
   parameter int FRAC_BITS = 4,
   parameter int RELU      = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        n_in,
   input  logic [7:0]        n_out,
   input  logic [7:0]        write_base_addr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] weight_data,
   input  logic [DATA_W-1:0] neuro_data,
   output logic              busy,
   output logic              wr_en,
   output logic [7:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   state_t                     state;
   logic [7:0]                 n_in_r, n_out_r, base_r;
   logic [7:0]                 term_ctr, neuron_ctr, out_ctr;
   logic                       s1_valid, s1_first, s1_last;
   logic signed [2*DATA_W-1:0] s1_prod;
   logic                       s2_valid, s2_last;
   logic signed [ACC_W-1:0]    acc;

   logic                       accept, first_term, last_term, degenerate;
   logic signed [ACC_W-1:0]    shifted;
   logic [DATA_W-1:0]          act;

   always_comb begin
      accept     = (state == RUN) && in_valid && !start;
      first_term = (term_ctr == '0);
      last_term  = (term_ctr == n_in_r - 8'd1);
      degenerate = (n_in == '0) || (n_out == '0);
      shifted    = acc >>> FRAC_BITS;
      if (RELU != 0 && shifted < 0)
         act = '0;
      else if (shifted > SAT_MAX)
         act = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN)
         act = SAT_MIN[DATA_W-1:0];
      else
         act = shifted[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         n_in_r     <= '0;
         n_out_r    <= '0;
         base_r     <= '0;
         term_ctr   <= '0;
         neuron_ctr <= '0;
         out_ctr    <= '0;
         s1_valid   <= 1'b0;
         s1_first   <= 1'b0;
         s1_last    <= 1'b0;
         s1_prod    <= '0;
         s2_valid   <= 1'b0;
         s2_last    <= 1'b0;
         acc        <= '0;
         busy       <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         done       <= 1'b0;
      end else if (start) begin
         // Restart discards everything in flight, including a write about to issue.
         n_in_r     <= n_in;
         n_out_r    <= n_out;
         base_r     <= write_base_addr;
         term_ctr   <= '0;
         neuron_ctr <= '0;
         out_ctr    <= '0;
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         s2_last    <= 1'b0;
         wr_en      <= 1'b0;
         busy       <= !degenerate;
         done       <= degenerate;
         state      <= degenerate ? DONE : RUN;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_prod  <= $signed(weight_data) * $signed(neuro_data);
            s1_first <= first_term;
            s1_last  <= last_term;
         end

         s2_valid <= s1_valid;
         s2_last  <= s1_valid && s1_last;
         if (s1_valid) begin
            if (s1_first)
               acc <= {{(ACC_W-2*DATA_W){s1_prod[2*DATA_W-1]}}, s1_prod};
            else
               acc <= acc + {{(ACC_W-2*DATA_W){s1_prod[2*DATA_W-1]}}, s1_prod};
         end

         wr_en <= s2_valid && s2_last;
         if (s2_valid && s2_last) begin
            wr_addr <= base_r + out_ctr;
            wr_data <= act;
            out_ctr <= out_ctr + 8'd1;
         end

         done <= 1'b0;
         case (state)
            IDLE: busy <= 1'b0;
            RUN: begin
               if (accept) begin
                  if (last_term) begin
                     term_ctr   <= '0;
                     neuron_ctr <= neuron_ctr + 8'd1;
                     if (neuron_ctr == n_out_r - 8'd1)
                        state <= DRAIN;
                  end else begin
                     term_ctr <= term_ctr + 8'd1;
                  end
               end
            end
            DRAIN: begin
               // out_ctr has already advanced past the index being written.
               if (wr_en && out_ctr == n_out_r) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed self-checking bench for neuron_accumulator; a RELU=0 instance shares the stimulus.
module tb_neuron_accumulator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] n_in = '0, n_out = '0, write_base_addr = '0;
   logic       in_valid = 1'b0;
   logic [7:0] weight_data = '0, neuro_data = '0;

   logic       busy, wr_en, done;
   logic [7:0] wr_addr, wr_data;
   logic       busy_l, wr_en_l, done_l;
   logic [7:0] wr_addr_l, wr_data_l;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   neuron_accumulator dut (
      .clk(clk), .reset(reset), .start(start), .n_in(n_in), .n_out(n_out),
      .write_base_addr(write_base_addr), .in_valid(in_valid),
      .weight_data(weight_data), .neuro_data(neuro_data),
      .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
   );

   neuron_accumulator #(.RELU(0)) dut_lin (
      .clk(clk), .reset(reset), .start(start), .n_in(n_in), .n_out(n_out),
      .write_base_addr(write_base_addr), .in_valid(in_valid),
      .weight_data(weight_data), .neuro_data(neuro_data),
      .busy(busy_l), .wr_en(wr_en_l), .wr_addr(wr_addr_l), .wr_data(wr_data_l), .done(done_l)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] log_addr[8];
   logic [7:0] log_data[8];
   int         log_cyc[8];
   int         wr_cnt, done_cnt, done_cyc, lin_cnt;
   logic       busy_at_done;
   logic [7:0] lin_data;

   always @(negedge clk) begin
      if (wr_en) begin
         if (wr_cnt < 8) begin
            log_addr[wr_cnt] = wr_addr;
            log_data[wr_cnt] = wr_data;
            log_cyc[wr_cnt]  = cyc;
         end
         wr_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
      if (wr_en_l) begin
         lin_data = wr_data_l;
         lin_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_cnt = 0; done_cnt = 0; done_cyc = -1; lin_cnt = 0;
      busy_at_done = 1'bx; lin_data = 'x;
      for (int unsigned i = 0; i < 8; i++) begin
         log_addr[i] = 'x; log_data[i] = 'x; log_cyc[i] = -1;
      end
   endtask

   task automatic do_start(input logic [7:0] ni, input logic [7:0] no, input logic [7:0] base);
      start = 1'b1; n_in = ni; n_out = no; write_base_addr = base;
      tick();
      start = 1'b0;
   endtask

   task automatic drive(input logic [7:0] w, input logic [7:0] n);
      in_valid = 1'b1; weight_data = w; neuro_data = n;
      tick();
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if ({busy, wr_en, wr_addr, wr_data, done} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", {busy, wr_en, wr_addr, wr_data, done});
      end
      checks++;
      if ({busy_l, wr_en_l, wr_addr_l, wr_data_l, done_l} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs_lin: got %h want 0", {busy_l, wr_en_l, wr_addr_l, wr_data_l, done_l});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int t_last;
      bit ok;
      clear_log();
      do_start(8'd2, 8'd1, 8'h10);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      drive(8'd16, 8'd32);
      t_last = cyc + 1;
      drive(8'd16, 8'd16);
      drive(8'd50, 8'd50);
      drive(8'd50, 8'd50);
      wait_done(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout: got no done want done"); end
      checks++;
      if (wr_cnt !== 1) begin errors++; $display("FAIL single_wr_count: got %0d want 1", wr_cnt); end
      checks++;
      if (log_addr[0] !== 8'h10) begin errors++; $display("FAIL single_addr: got %h want 10", log_addr[0]); end
      checks++;
      if (log_data[0] !== 8'd48) begin errors++; $display("FAIL single_data: got %0d want 48", log_data[0]); end
      checks++;
      if (log_cyc[0] !== t_last + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", log_cyc[0], t_last + 2); end
      checks++;
      if (done_cyc !== t_last + 3) begin errors++; $display("FAIL single_done_cycle: got %0d want %0d", done_cyc, t_last + 3); end
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
      checks++;
      if (busy_at_done !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b want 0", busy_at_done); end
   endtask

   task automatic test_wrap_bubbles();
      int pat[9] = '{1, 0, 1, 1, 0, 0, 1, 1, 1};
      bit ok;
      clear_log();
      do_start(8'd3, 8'd2, 8'hFF);
      foreach (pat[i]) begin
         in_valid = pat[i][0]; weight_data = 8'd16; neuro_data = 8'd16;
         tick();
      end
      wait_done(30, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_timeout: got no done want done"); end
      checks++;
      if (wr_cnt !== 2) begin errors++; $display("FAIL wrap_wr_count: got %0d want 2", wr_cnt); end
      checks++;
      if (log_addr[0] !== 8'hFF || log_addr[1] !== 8'h00) begin
         errors++; $display("FAIL wrap_addr: got %h,%h want ff,00", log_addr[0], log_addr[1]);
      end
      checks++;
      if (log_data[0] !== 8'd48 || log_data[1] !== 8'd48) begin
         errors++; $display("FAIL wrap_data: got %0d,%0d want 48,48", log_data[0], log_data[1]);
      end
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_sat_relu();
      bit ok;
      clear_log();
      do_start(8'd4, 8'd1, 8'h20);
      repeat (4) drive(8'd127, 8'd127);
      wait_done(20, ok);
      checks++;
      if (!ok || log_data[0] !== 8'd127) begin errors++; $display("FAIL sat_pos: got %0d want 127", log_data[0]); end
      checks++;
      if (lin_data !== 8'd127) begin errors++; $display("FAIL sat_pos_lin: got %0d want 127", lin_data); end

      clear_log();
      do_start(8'd1, 8'd1, 8'h21);
      drive(8'hF0, 8'd16);
      wait_done(20, ok);
      checks++;
      if (!ok || log_data[0] !== 8'h00 || log_addr[0] !== 8'h21) begin
         errors++; $display("FAIL relu_clamp: got %h@%h want 00@21", log_data[0], log_addr[0]);
      end
      checks++;
      if (lin_data !== 8'hF0) begin errors++; $display("FAIL linear_neg: got %h want f0", lin_data); end

      clear_log();
      do_start(8'd4, 8'd1, 8'h22);
      repeat (4) drive(8'h80, 8'd127);
      wait_done(20, ok);
      checks++;
      if (!ok || log_data[0] !== 8'h00) begin errors++; $display("FAIL relu_neg_sat: got %h want 00", log_data[0]); end
      checks++;
      if (lin_data !== 8'h80 || lin_cnt !== 1) begin
         errors++; $display("FAIL sat_neg_lin: got %h (%0d writes) want 80 (1 write)", lin_data, lin_cnt);
      end
   endtask

   task automatic test_abort();
      bit ok;
      clear_log();
      do_start(8'd4, 8'd2, 8'h30);
      repeat (5) drive(8'd10, 8'd10);
      in_valid = 1'b1; weight_data = 8'd100; neuro_data = 8'd100;
      do_start(8'd1, 8'd1, 8'h40);
      drive(8'd32, 8'd16);
      wait_done(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL abort_timeout: got no done want done"); end
      checks++;
      if (wr_cnt !== 1) begin errors++; $display("FAIL abort_wr_count: got %0d want 1", wr_cnt); end
      checks++;
      if (log_addr[0] !== 8'h40 || log_data[0] !== 8'd32) begin
         errors++; $display("FAIL abort_write: got %0d@%h want 32@40", log_data[0], log_addr[0]);
      end
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL abort_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_degenerate(input logic [7:0] ni, input logic [7:0] no);
      int s;
      clear_log();
      do_start(ni, no, 8'h50);
      s = cyc;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL degen_%0d_%0d_pulse: got done=%b busy=%b want done=1 busy=0", ni, no, done, busy);
      end
      repeat (5) tick();
      checks++;
      if (done_cnt !== 1 || done_cyc !== s) begin
         errors++; $display("FAIL degen_%0d_%0d_done: got %0d pulses at %0d want 1 at %0d", ni, no, done_cnt, done_cyc, s);
      end
      checks++;
      if (wr_cnt !== 0) begin errors++; $display("FAIL degen_%0d_%0d_writes: got %0d want 0", ni, no, wr_cnt); end
   endtask

   task automatic test_reset_in_run();
      clear_log();
      do_start(8'd2, 8'd2, 8'h60);
      drive(8'd16, 8'd16);
      drive(8'd16, 8'd16);
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      checks++;
      if ({busy, wr_en, wr_addr, wr_data, done} !== 19'd0) begin
         errors++; $display("FAIL run_reset_outputs: got %h want 0", {busy, wr_en, wr_addr, wr_data, done});
      end
      reset = 1'b0;
      repeat (10) tick();
      checks++;
      if (wr_cnt !== 0 || done_cnt !== 0 || busy !== 1'b0) begin
         errors++; $display("FAIL run_reset_quiet: got %0d writes %0d dones busy=%b want 0 0 0", wr_cnt, done_cnt, busy);
      end
   endtask

   initial begin
      clear_log();
      test_reset();
      test_single();
      test_wrap_bubbles();
      test_sat_relu();
      test_abort();
      test_degenerate(8'd3, 8'd0);
      test_degenerate(8'd0, 8'd3);
      test_reset_in_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
- Data-side consumer of one fully-connected layer pass: accepts the weight/neuron operand stream returned from memory, multiply-accumulates n_in terms per output neuron, and writes each activated, saturated result to neuron RAM.
- Sits between the weight/neuron RAM read ports and the neuron RAM write port; the read-address generator issues the addresses, and this block closes the loop on the write side.

Parameters:
- DATA_W, 8, width of weights, neuron values and written results (signed two's complement).
- ACC_W, 24, accumulator width (16-bit product + 8 bits of headroom for up to 255 terms).
- FRAC_BITS, 4, fixed-point fraction bits; the result is acc >>> FRAC_BITS.
- RELU, 1, 1 = clamp negative results to 0 before saturation; 0 = linear.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  latches n_in/n_out/write_base_addr and begins a pass; also aborts any pass in progress
- n_in  in  8  terms per output neuron (previous layer size)
- n_out  in  8  output neurons to produce
- write_base_addr  in  8  neuron RAM address of the first result
- in_valid  in  1  weight_data/neuro_data hold a valid operand pair this cycle
- weight_data  in  DATA_W  signed weight
- neuro_data  in  DATA_W  signed neuron value
- busy  out  1  pass in progress
- wr_en  out  1  write strobe, one cycle per result
- wr_addr  out  8  write_base_addr + result index (mod 256)
- wr_data  out  DATA_W  activated, saturated result
- done  out  1  one-cycle pulse at the end of a pass

Behaviour:
- Reset: every output is 0; state IDLE; counters, pipeline valids and accumulator are cleared. Reset overrides start.
- States are IDLE, RUN, DRAIN and DONE.
- start (any state):
  - Latches the parameters and clears term_ctr, neuron_ctr, out_ctr and all pipeline valids. A partial pass is discarded and produces no wr_en.
  - If n_in==0 or n_out==0, go to DONE; otherwise go to RUN.
  - busy=1 from the cycle after start.
- RUN: each in_valid cycle accepts one pair.
  - term_ctr increments; the pair is tagged first (term_ctr==0) and last (term_ctr==n_in-1).
  - On last, term_ctr wraps to 0 and neuron_ctr increments.
  - When the last term of neuron n_out-1 is accepted, go to DRAIN.
  - in_valid low inserts a bubble; there is no timeout.
- Pipeline:
  - S1 registers the signed product (2*DATA_W bits) with its valid, first and last tags.
  - S2: if first, acc = sext(product); otherwise acc = acc + sext(product). Wrap in ACC_W is permitted but cannot occur at the defaults.
  - On a valid last in S2, the output register is loaded the next cycle: wr_en=1, wr_addr=write_base_addr+out_ctr, wr_data=f(final acc). out_ctr increments after each write.
  - Latency: last operand accepted at cycle t gives wr_en at t+2.
- f(acc):
  - s = acc >>> FRAC_BITS (arithmetic, floor).
  - If RELU and s<0, then s=0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- wr_en is a single-cycle strobe; wr_addr and wr_data are don't-care but held when wr_en=0.
- DRAIN: in_valid is ignored. The cycle after the wr_en for result n_out-1, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
- IDLE: in_valid is ignored; busy=0.
- start coincident with an in_valid: the pair is not accepted (it belongs to no pass).
- wr_addr wraps modulo 256.

Test Plan:
- n_in=2, n_out=1, base=0x10, FRAC=4; pairs (16,32),(16,16) on consecutive cycles → acc=768, one wr_en at t+2 with wr_addr=0x10, wr_data=48; done the next cycle.
- n_in=3, n_out=2, base=0xFF; in_valid toggled 1,0,1,1,0,0,1,1,1; all pairs (16,16) → two writes of 48, wr_addr 0xFF then 0x00; exactly 2 wr_en; done once.
- Saturation and ReLU with RELU=1: n_in=4, all pairs (127,127) → 127. Next pass: n_in=1, pair (-16,16) → 0. With RELU=0, the same pair → -16 (0xF0); n_in=4 of (-128,127) → -128.
- Abort: n_in=4, n_out=2; issue start again after 5 accepted pairs with n_in=1, n_out=1, base=0x40, pair (32,16) → no writes from the first pass, single write 0x40 ← 32.
- Degenerate and reset: start with n_out=0 → done pulse the cycle after start, no wr_en. Start with n_in=0 → same. Reset asserted in RUN → all outputs 0 next cycle; no done, no further wr_en.
